addsub_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one combinational 13-bit add/subtract unit between NUM_REQ requesters.
- Accepts one operation at a time over a valid/ready handshake and drives the shared unit from registered operands.
- Captures the 14-bit result and returns it on a single tagged response channel with backpressure.
- Sits between the front-end operand sources (keypad/switch capture, sequencers) and the arithmetic datapath.

---
 rtl/addsub_arbiter.sv | 150 +++++++++++++++
 tb/tb_addsub_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin front end for one shared combinational
// add/subtract unit. One operation is in flight at a time:
// IDLE (grant) -> EXEC (unit is driven) -> RESP (hold result until taken).
//
// Handshake rule for both channels: a transfer happens on a rising edge
// where valid and ready are both high. The consumer may hold ready low
// indefinitely, and the payload stays stable while valid is waiting.
// A requester may drop valid at any time before it is granted.
module addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 13,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_x1,
  input  logic [NUM_REQ*WIDTH-1:0]   req_x2,
  input  logic [NUM_REQ-1:0]         req_sub,
  output logic [WIDTH-1:0]           au_x1,
  output logic [WIDTH-1:0]           au_x2,
  output logic                       au_sign,
  input  logic [WIDTH:0]             au_s,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH:0]             rsp_data,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_grant;
  logic [WIDTH-1:0]    r_au_x1;
  logic [WIDTH-1:0]    r_au_x2;
  logic                r_au_sign;
  logic                r_rsp_valid;
  logic [WIDTH:0]      r_rsp_data;
  logic [ID_W-1:0]     r_rsp_id;

  logic                w_any;
  logic [ID_W-1:0]     w_grant;
  logic [NUM_REQ-1:0]  w_ready;
  logic                w_accept;
  logic                w_rsp_done;
  logic [ID_W-1:0]     w_ptr_nxt;
  int                  w_idx;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_any && req_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = ID_W'(w_idx);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state and the combinational accept strobe (IDLE only, one-hot).
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (resetn && w_any) begin
          w_ready[w_grant] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pointer moves to the requester after the one just served.
  always_comb begin
    if (r_grant == ID_W'(NUM_REQ - 1)) w_ptr_nxt = '0;
    else                               w_ptr_nxt = r_grant + 1'b1;
  end

  // Datapath: latch operands on accept, capture result after EXEC, retire on handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_au_x1     <= '0;
      r_au_x2     <= '0;
      r_au_sign   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      if (w_accept) begin
        r_au_x1   <= req_x1[int'(w_grant)*WIDTH +: WIDTH];
        r_au_x2   <= req_x2[int'(w_grant)*WIDTH +: WIDTH];
        r_au_sign <= req_sub[w_grant];
        r_grant   <= w_grant;
      end
      if (r_state == S_EXEC) begin
        r_rsp_data  <= au_s;
        r_rsp_id    <= r_grant;
        r_rsp_valid <= 1'b1;
      end
      if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
        r_rr_ptr    <= w_ptr_nxt;
      end
    end
  end

  assign req_ready = w_ready;
  assign au_x1     = r_au_x1;
  assign au_x2     = r_au_x2;
  assign au_sign   = r_au_sign;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: vector table of single operations, then
// round-robin, backpressure and mid-operation reset sequences.
module tb_addsub_arbiter;
  localparam int N  = 4;
  localparam int W  = 13;
  localparam int IW = 2;
  localparam int EW = IW + W + 1;

  logic               clk;
  logic               resetn;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_x1;
  logic [N*W-1:0]     req_x2;
  logic [N-1:0]       req_sub;
  logic [W-1:0]       au_x1;
  logic [W-1:0]       au_x2;
  logic               au_sign;
  logic [W:0]         au_s;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [W:0]         rsp_data;
  logic [IW-1:0]      rsp_id;
  logic               busy;
  logic [1:0]         dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [EW-1:0] exp_q[$];

  addsub_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .req_sub(req_sub),
    .au_x1(au_x1), .au_x2(au_x2), .au_sign(au_sign), .au_s(au_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Shared add/sub unit model (external to the DUT).
  assign au_s = au_sign ? ({1'b0, au_x2} + {1'b0, ~au_x1} + 14'd1)
                        : ({1'b0, au_x2} + {1'b0, au_x1});

  // Clock / cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x1, input logic [W-1:0] x2, input logic sub);
    logic [W:0] r;
    if (sub) r = {1'b0, x2} + {1'b0, ~x1} + 1'b1;
    else     r = {1'b0, x2} + {1'b0, x1};
    return r;
  endfunction

  // Scoreboard: pop one expectation per response handshake.
  always @(negedge clk) begin
    if (resetn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {16'd0, rsp_id, rsp_data}, 32'hFFFF_FFFF);
      end else begin
        check("rsp_id_data", {16'd0, rsp_id, rsp_data}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic set_req(input int id, input logic [W-1:0] x1, input logic [W-1:0] x2, input logic sub);
    req_x1[id*W +: W] = x1;
    req_x2[id*W +: W] = x2;
    req_sub[id]       = sub;
  endtask

  task automatic push_exp(input int id, input logic [W-1:0] x1, input logic [W-1:0] x2, input logic sub);
    logic [IW-1:0] idv;
    idv = IW'(id);
    exp_q.push_back({idv, model(x1, x2, sub)});
  endtask

  // Wait (bounded) for a grant; check it is the expected one-hot; then pass the accept edge.
  task automatic wait_grant(input int id, output int gcyc);
    logic [N-1:0] exp_rdy;
    exp_rdy = '0;
    exp_rdy[id] = 1'b1;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (req_ready != '0) break;
      @(negedge clk);
      #1;
    end
    gcyc = cyc;
    check("grant", {28'd0, req_ready}, {28'd0, exp_rdy});
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("return_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    int          id;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic        sub;
    logic [W:0]  exp;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int g, gprev;
    logic [W:0] hold_d;
    logic [IW-1:0] hold_i;
    logic [W-1:0] rx1, rx2;
    logic rsub;
    int rid;

    resetn = 1'b0; req_valid = '0; req_x1 = '0; req_x2 = '0; req_sub = '0; rsp_ready = 1'b1;

    vecs[0] = '{0, 13'd23,    13'd100,   1'b0, 14'h007B};
    vecs[1] = '{2, 13'd5,     13'd3,     1'b1, 14'h1FFE};
    vecs[2] = '{2, 13'd3,     13'd5,     1'b1, 14'h2002};
    vecs[3] = '{1, 13'h1FFF,  13'd1,     1'b0, 14'h2000};
    vecs[4] = '{1, 13'd0,     13'd0,     1'b1, 14'h2000};
    vecs[5] = '{3, 13'h1FFF,  13'h1FFF,  1'b0, 14'h3FFE};
    vecs[6] = '{2, 13'h0100,  13'h0050,  1'b0, 14'h0150};
    vecs[7] = '{0, 13'h1000,  13'h1000,  1'b1, 14'h2000};

    // Reset state.
    repeat (2) @(negedge clk);
    req_valid = 4'hF;
    #1;
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_outputs", {rsp_valid, busy, au_sign, 1'b0, rsp_id, rsp_data, au_x1}, 32'd0);
    check("rst_au_x2", {19'd0, au_x2}, 32'd0);
    req_valid = '0;
    @(negedge clk);
    resetn = 1'b1;

    // Table of single operations.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_req(vecs[i].id, vecs[i].x1, vecs[i].x2, vecs[i].sub);
      exp_q.push_back({IW'(vecs[i].id), vecs[i].exp});
      req_valid[vecs[i].id] = 1'b1;
      wait_grant(vecs[i].id, g);
      req_valid = '0;
      @(negedge clk);
      check("exec_ops", {1'b0, au_sign, au_x1, 4'd0, au_x2}, {1'b0, vecs[i].sub, vecs[i].x1, 4'd0, vecs[i].x2});
      check("exec_state", {30'd0, busy, rsp_valid}, 32'd2);
      @(negedge clk);
      check("rsp_latency", {31'd0, rsp_valid}, 32'd1);
      wait_idle();
    end

    // Random single operations.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rid = $urandom_range(0, N-1);
      rx1 = W'($urandom_range(0, (1 << W) - 1));
      rx2 = W'($urandom_range(0, (1 << W) - 1));
      rsub = 1'($urandom_range(0, 1));
      set_req(rid, rx1, rx2, rsub);
      push_exp(rid, rx1, rx2, rsub);
      req_valid[rid] = 1'b1;
      wait_grant(rid, g);
      req_valid = '0;
      wait_idle();
    end

    // Round-robin from rr_ptr=0 with all requesters valid.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, W'(i*10 + 1), W'(13'h100 + i), i[0]);
    for (int i = 0; i < 5; i++) push_exp(i % N, W'((i % N)*10 + 1), W'(13'h100 + (i % N)), 1'((i % N) & 1));
    req_valid = 4'hF;
    gprev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(i % N, g);
      if (i > 0) check("issue_interval", g - gprev, 32'd3);
      gprev = g;
      if (i < 4) @(negedge clk);
    end
    req_valid = '0;
    wait_idle();

    // After serving 1, with only 1 and 3 valid: 3 then 1.
    do_reset();
    @(negedge clk);
    set_req(1, 13'd7, 13'd9, 1'b0);
    set_req(3, 13'd2, 13'd40, 1'b1);
    push_exp(1, 13'd7, 13'd9, 1'b0);
    req_valid[1] = 1'b1;
    wait_grant(1, g);
    req_valid = '0;
    wait_idle();
    push_exp(3, 13'd2, 13'd40, 1'b1);
    push_exp(1, 13'd7, 13'd9, 1'b0);
    req_valid = 4'b1010;
    wait_grant(3, g);
    @(negedge clk);
    wait_grant(1, g);
    req_valid = '0;
    wait_idle();

    // Backpressure: response held while rsp_ready is low.
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(2, 13'd300, 13'd1234, 1'b1);
    set_req(0, 13'd11, 13'd22, 1'b0);
    push_exp(2, 13'd300, 13'd1234, 1'b1);
    req_valid[2] = 1'b1;
    wait_grant(2, g);
    req_valid = 4'b0001;
    push_exp(0, 13'd11, 13'd22, 1'b0);
    repeat (2) @(negedge clk);
    hold_d = rsp_data;
    hold_i = rsp_id;
    check("bp_first", {17'd0, rsp_valid, hold_i, 1'b0, hold_d}, {17'd0, 1'b1, 2'd2, 1'b0, model(13'd300, 13'd1234, 1'b1)});
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", {15'd0, busy, rsp_valid, rsp_id, rsp_data}, {15'd0, 1'b1, 1'b1, hold_i, hold_d});
      check("bp_no_ready", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle", {31'd0, busy}, 32'd0);
    wait_grant(0, g);
    req_valid = '0;
    wait_idle();

    // Leave rr_ptr=2, then reset in the middle of EXEC.
    @(negedge clk);
    set_req(1, 13'd50, 13'd60, 1'b0);
    push_exp(1, 13'd50, 13'd60, 1'b0);
    req_valid[1] = 1'b1;
    wait_grant(1, g);
    req_valid = '0;
    wait_idle();
    set_req(3, 13'd999, 13'd888, 1'b1);
    req_valid[3] = 1'b1;
    wait_grant(3, g);
    req_valid = '0;
    @(negedge clk);
    check("pre_rst_exec", {31'd0, busy}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("async_rst_outs", {rsp_valid, busy, au_sign, 1'b0, rsp_id, rsp_data, au_x1}, 32'd0);
    check("async_rst_x2", {19'd0, au_x2, req_ready}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    push_exp(1, 13'd50, 13'd60, 1'b0);
    req_valid = 4'b1010;
    wait_grant(1, g);
    req_valid = '0;
    wait_idle();

    // Drain and report.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
